// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter states and frame sizing.
// Reused by the transmitter, the receiver and the benches.
package uart_pkg;

    typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_e;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;

    function automatic int frame_bits(input int data_w, input int parity, input int stop_bits);
        return 1 + data_w + ((parity != 0) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/tx_fifo.sv
// Synchronous DEPTH-entry FIFO with flush and sticky overflow; rdata shows the head combinationally.
// Writes while full are dropped and flag ovf; flush clears contents and ovf and beats a same-cycle write.
module tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic              ovf_q;
    logic              push_ok, pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign ovf     = ovf_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            // a pop in the same cycle does not rescue a write against a full FIFO
            if (push && full) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered UART transmitter: FIFO feeding a start/data/parity/stop serialiser, TX low 2 edges after a write to an idle block.
// Writers never stall: writes while full are dropped and recorded in the sticky ovf flag.
module uart_tx_buf
    import uart_pkg::*;
#(
    parameter int BAUD_DIV  = 2604,
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 4,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     flush,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf,
    output logic                     busy,
    output logic                     tx_done,
    output logic                     TX
);

    localparam int BW = $clog2(BAUD_DIV);
    localparam int NW = 4;

    tx_state_e         state_q, state_d;
    logic [BW-1:0]     baud_q;
    logic [NW-1:0]     bit_q;
    logic [DATA_W-1:0] shift_q;
    logic              par_q;
    logic [DATA_W-1:0] fifo_rdata;
    logic              pop, tick, data_last, stop_last;

    tx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (wr_en),
        .pop   (pop),
        .flush (flush),
        .wdata (wr_data),
        .rdata (fifo_rdata),
        .full  (full),
        .empty (empty),
        .count (count),
        .ovf   (ovf)
    );

    assign tick      = (baud_q == BW'(BAUD_DIV - 1));
    assign data_last = tick && (bit_q == NW'(DATA_W - 1));
    assign stop_last = (state_q == STOP) && tick && (bit_q == NW'(STOP_BITS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:             if (!empty)    state_d = START;
            START:            if (tick)      state_d = DATA;
            DATA:             if (data_last) state_d = (PARITY != 0) ? uart_pkg::PARITY : STOP;
            uart_pkg::PARITY: if (tick)      state_d = STOP;
            STOP:             if (stop_last) state_d = empty ? IDLE : START;
            default:                         state_d = IDLE;
        endcase
    end

    always_comb begin
        TX = 1'b1;
        case (state_q)
            START:            TX = 1'b0;
            DATA:             TX = shift_q[0];
            uart_pkg::PARITY: TX = par_q;
            default:          TX = 1'b1;
        endcase
        busy    = (state_q != IDLE);
        tx_done = stop_last;
        // back-to-back frames pop on the final stop cycle, so no idle bit appears
        pop     = !empty && ((state_q == IDLE) || stop_last);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
        end else begin
            if (pop) begin
                shift_q <= fifo_rdata;
                par_q   <= (PARITY == 2) ? ~^fifo_rdata : ^fifo_rdata;
            end else if (state_q == DATA && tick) begin
                shift_q <= shift_q >> 1;
            end
            // restart bit timing on every state entry so frames never drift
            if (state_d != state_q) begin
                baud_q <= '0;
                bit_q  <= '0;
            end else begin
                baud_q <= tick ? '0 : baud_q + BW'(1);
                if (tick) bit_q <= bit_q + NW'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Bench for uart_tx_buf: four parameter variants share one clock/reset; serial frames are
// decoded mid-bit and compared with frames rebuilt from data, parity rule and stop count.
module tb_uart_tx_buf;

    localparam int BD  = 16;
    localparam int DEP = 4;
    localparam int DWS   [4] = '{8, 8, 9, 8};
    localparam int PARS  [4] = '{0, 2, 1, 0};
    localparam int STOPS [4] = '{1, 1, 1, 2};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en   [4];
    logic       flush   [4];
    logic [8:0] wd      [4];
    logic       full    [4];
    logic       empty   [4];
    logic       ovf     [4];
    logic       busy    [4];
    logic       tx_done [4];
    logic       tx      [4];
    logic [2:0] cnt     [4];

    int n_tests = 0;
    int n_fail  = 0;
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    uart_tx_buf #(.BAUD_DIV(BD), .DATA_W(DWS[0]), .DEPTH(DEP), .PARITY(PARS[0]), .STOP_BITS(STOPS[0])) u0 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en[0]), .wr_data(wd[0][7:0]), .flush(flush[0]),
        .full(full[0]), .empty(empty[0]), .count(cnt[0]), .ovf(ovf[0]), .busy(busy[0]),
        .tx_done(tx_done[0]), .TX(tx[0]));

    uart_tx_buf #(.BAUD_DIV(BD), .DATA_W(DWS[1]), .DEPTH(DEP), .PARITY(PARS[1]), .STOP_BITS(STOPS[1])) u1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en[1]), .wr_data(wd[1][7:0]), .flush(flush[1]),
        .full(full[1]), .empty(empty[1]), .count(cnt[1]), .ovf(ovf[1]), .busy(busy[1]),
        .tx_done(tx_done[1]), .TX(tx[1]));

    uart_tx_buf #(.BAUD_DIV(BD), .DATA_W(DWS[2]), .DEPTH(DEP), .PARITY(PARS[2]), .STOP_BITS(STOPS[2])) u2 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en[2]), .wr_data(wd[2]), .flush(flush[2]),
        .full(full[2]), .empty(empty[2]), .count(cnt[2]), .ovf(ovf[2]), .busy(busy[2]),
        .tx_done(tx_done[2]), .TX(tx[2]));

    uart_tx_buf #(.BAUD_DIV(BD), .DATA_W(DWS[3]), .DEPTH(DEP), .PARITY(PARS[3]), .STOP_BITS(STOPS[3])) u3 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en[3]), .wr_data(wd[3][7:0]), .flush(flush[3]),
        .full(full[3]), .empty(empty[3]), .count(cnt[3]), .ovf(ovf[3]), .busy(busy[3]),
        .tx_done(tx_done[3]), .TX(tx[3]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Serial bit idx of a frame carrying data on variant d, from the framing rules.
    function automatic logic exp_bit(input int d, input logic [8:0] data, input int idx);
        int dw   = DWS[d];
        int ones = 0;
        if (idx == 0) return 1'b0;
        if (idx <= dw) return data[idx-1];
        if (PARS[d] != 0 && idx == dw + 1) begin
            for (int i = 0; i < dw; i++) ones += int'(data[i]);
            return (PARS[d] == 1) ? logic'(ones % 2) : logic'(1 - ones % 2);
        end
        return 1'b1;
    endfunction

    task automatic push(input int d, input logic [8:0] v);
        @(negedge clk);
        wr_en[d] = 1'b1;
        wd[d]    = v;
        @(negedge clk);
        wr_en[d] = 1'b0;
    endtask

    // n writes on consecutive clocks into an idle block; one entry leaves for the
    // serialiser after the first write, so DEPTH+1 words are accepted at most.
    task automatic burst(input int d, input int n);
        logic [8:0] v;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            v = 9'($urandom) & 9'((1 << DWS[d]) - 1);
            wr_en[d] = 1'b1;
            wd[d]    = v;
            if (i < DEP + 1) exp_q.push_back(v);
        end
        @(negedge clk);
        wr_en[d] = 1'b0;
    endtask

    // Consume exp_q as back-to-back frames; s0 = samples of the first frame already elapsed
    // (sample 1 is the first negedge with TX low). Optionally pulse flush at sample flush_at of frame 0.
    task automatic check_frames(input int d, input int s0, input int flush_at);
        int L = BD * uart_pkg::frame_bits(DWS[d], PARS[d], STOPS[d]);
        int s = s0;
        int k = 0;
        logic [8:0] data;
        logic done_ok;
        while (exp_q.size() > 0) begin
            data    = exp_q.pop_front();
            done_ok = 1'b1;
            while (s < L) begin
                @(negedge clk);
                s++;
                flush[d] = (k == 0 && s == flush_at);
                if ((s - 1) % BD == BD / 2)
                    check($sformatf("d%0d frame%0d bit%0d", d, k, (s - 1) / BD), 32'(tx[d]),
                          32'(exp_bit(d, data, (s - 1) / BD)));
                if (tx_done[d] !== (s == L)) done_ok = 1'b0;
            end
            check($sformatf("d%0d frame%0d tx_done at clk %0d", d, k, L), 32'(done_ok), 32'd1);
            s = 0;
            k++;
        end
        flush[d] = 1'b0;
    endtask

    initial begin
        int   n;
        int   d;
        logic quiet;
        for (int i = 0; i < 4; i++) begin
            wr_en[i] = 1'b0;
            flush[i] = 1'b0;
            wd[i]    = '0;
        end

        // reset state
        repeat (3) @(negedge clk);
        check("reset TX", 32'(tx[0]), 32'd1);
        check("reset empty", 32'(empty[0]), 32'd1);
        check("reset count", 32'(cnt[0]), 32'd0);
        check("reset busy", 32'(busy[0]), 32'd0);
        check("reset full", 32'(full[0]), 32'd0);
        check("reset ovf", 32'(ovf[0]), 32'd0);
        rst_n = 1'b1;
        quiet = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (tx[0] !== 1'b1 || busy[0] !== 1'b0) quiet = 1'b0;
        end
        check("idle after reset", 32'(quiet), 32'd1);

        // single frame 8'h67
        push(0, 9'h067);
        check("TX high 1 edge after wr", 32'(tx[0]), 32'd1);
        @(negedge clk);
        check("TX low 2 edges after wr", 32'(tx[0]), 32'd0);
        exp_q.delete();
        exp_q.push_back(9'h067);
        check_frames(0, 1, 0);
        @(negedge clk);
        check("busy after single", 32'(busy[0]), 32'd0);

        // bursts: directed overflow burst of 6, then random lengths
        for (int it = 0; it < 3; it++) begin
            n = (it == 0) ? 6 : int'($urandom_range(1, 6));
            burst(0, n);
            check($sformatf("burst%0d count", n), 32'(cnt[0]),
                  (n == 1) ? 32'd1 : 32'(((n < DEP + 1) ? n : DEP + 1) - 1));
            check($sformatf("burst%0d full", n), 32'(full[0]), (n >= DEP + 1) ? 32'd1 : 32'd0);
            check($sformatf("burst%0d ovf", n), 32'(ovf[0]), (n > DEP + 1) ? 32'd1 : 32'd0);
            check_frames(0, n - 1, 0);
            @(negedge clk);
            check("busy after burst", 32'(busy[0]), 32'd0);
            check("empty after burst", 32'(empty[0]), 32'd1);
            flush[0] = 1'b1;
            @(negedge clk);
            flush[0] = 1'b0;
            check("ovf cleared by flush", 32'(ovf[0]), 32'd0);
        end

        // parity: 8'h07 odd on u1, 9'h007 and 9'h100 even on u2, then random words
        push(1, 9'h007);
        exp_q.delete();
        exp_q.push_back(9'h007);
        check_frames(1, 0, 0);
        push(2, 9'h007);
        exp_q.push_back(9'h007);
        check_frames(2, 0, 0);
        push(2, 9'h100);
        exp_q.push_back(9'h100);
        check_frames(2, 0, 0);
        for (int i = 0; i < 4; i++) begin
            d = 1 + (i % 2);
            exp_q.delete();
            exp_q.push_back(9'($urandom) & 9'((1 << DWS[d]) - 1));
            push(d, exp_q[0]);
            check_frames(d, 0, 0);
        end

        // two stop bits, flush during frame 1: frame 2 never starts
        burst(3, 2);
        check("stop2 count", 32'(cnt[3]), 32'd1);
        void'(exp_q.pop_back());
        check_frames(3, 1, 80);
        quiet = 1'b1;
        repeat (2 * 176) begin
            @(negedge clk);
            if (tx[3] !== 1'b1) quiet = 1'b0;
        end
        check("no frame after flush", 32'(quiet), 32'd1);
        check("flush empty", 32'(empty[3]), 32'd1);
        check("flush ovf", 32'(ovf[3]), 32'd0);
        check("flush busy", 32'(busy[3]), 32'd0);

        // async reset in the middle of DATA with entries queued
        burst(0, 4);
        repeat (40) @(negedge clk);
        check("pre-reset TX in DATA", 32'(busy[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid-frame reset TX", 32'(tx[0]), 32'd1);
        check("mid-frame reset count", 32'(cnt[0]), 32'd0);
        check("mid-frame reset busy", 32'(busy[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        push(0, 9'h0A5);
        exp_q.push_back(9'h0A5);
        check_frames(0, 0, 0);
        @(negedge clk);
        check("busy after A5", 32'(busy[0]), 32'd0);
        check("empty after A5", 32'(empty[0]), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
